// File: rtl/window_scheduler_if.sv
// Control interface between the window scheduler, its input/output FIFOs and the
// line-buffer/operator datapath.
interface window_scheduler_if;
    // A pop happens on every cycle fifo_in_rd_en is high; it is only raised while
    // fifo_in_empty is low. A write happens on every cycle fifo_out_wr_en is high;
    // it is only raised while fifo_out_full is low. Neither side waits for an ack.
    logic fifo_in_empty;
    logic fifo_in_rd_en;
    logic fifo_out_full;
    logic fifo_out_wr_en;
    logic shift_en;
    logic pad_sel;
    logic op_en;

    modport master (
        input  fifo_in_empty,
        input  fifo_out_full,
        output fifo_in_rd_en,
        output fifo_out_wr_en,
        output shift_en,
        output pad_sel,
        output op_en
    );

    modport slave (
        output fifo_in_empty,
        output fifo_out_full,
        input  fifo_in_rd_en,
        input  fifo_out_wr_en,
        input  shift_en,
        input  pad_sel,
        input  op_en
    );
endinterface

// File: rtl/window_scheduler.sv
// Raster scheduler for a zero-padded sliding-window filter: pops pixels, injects pads,
// stalls, and writes only fully formed windows. Optional stats: WINDOW_SCHEDULER_STATS_EN.
module window_scheduler #(
    parameter int IMG_WIDTH   = 720,
    parameter int IMG_HEIGHT  = 540,
    parameter int WINDOW_SIZE = 3,
    parameter int OP_LATENCY  = 1,
    parameter int CW          = 13
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    window_scheduler_if.master        sched,
    output logic                      busy,
    output logic                      frame_done,
    output logic [1:0]                state_dbg
`ifdef WINDOW_SCHEDULER_STATS_EN
    ,
    output logic [15:0]               frame_count,
    output logic [31:0]               stall_count
`endif
);

    localparam int P = WINDOW_SIZE / 2;

    localparam logic [CW-1:0] X_LAST   = CW'(IMG_WIDTH + 2 * P - 1);
    localparam logic [CW-1:0] Y_LAST   = CW'(IMG_HEIGHT + 2 * P - 1);
    localparam logic [CW-1:0] INT_LO   = CW'(P);
    localparam logic [CW-1:0] X_INT_HI = CW'(IMG_WIDTH + P - 1);
    localparam logic [CW-1:0] Y_INT_HI = CW'(IMG_HEIGHT + P - 1);
    localparam logic [CW-1:0] EMIT_LO  = CW'(2 * P);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FILL   = 2'd1,
        S_STREAM = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [CW-1:0]         px;
    logic [CW-1:0]         py;
    logic [OP_LATENCY-1:0] vld;
    logic [OP_LATENCY-1:0] vld_nxt;
    logic                  done_nxt;

    logic vld_last;
    logic adv;
    logic active;
    logic interior;
    logic emits;
    logic at_first_emit;
    logic at_last;
    logic step;

    assign vld_last      = vld[OP_LATENCY-1];
    // A pending result that cannot be written freezes the whole operator pipeline.
    assign adv           = !(vld_last && sched.fifo_out_full);
    assign active        = (state == S_FILL) || (state == S_STREAM);
    assign interior      = (px >= INT_LO) && (px <= X_INT_HI) &&
                           (py >= INT_LO) && (py <= Y_INT_HI);
    assign emits         = (px >= EMIT_LO) && (py >= EMIT_LO);
    assign at_first_emit = (px == EMIT_LO) && (py == EMIT_LO);
    assign at_last       = (px == X_LAST) && (py == Y_LAST);
    // Pads never wait on the input FIFO, but they cannot overtake a stalled pixel.
    assign step          = adv && active && (!interior || !sched.fifo_in_empty);
    assign vld_nxt       = adv ? ((vld << 1) | OP_LATENCY'(step && emits)) : vld;

    assign sched.fifo_in_rd_en  = step && interior;
    assign sched.shift_en       = step;
    assign sched.pad_sel        = step && !interior;
    assign sched.op_en          = adv && (state != S_IDLE);
    assign sched.fifo_out_wr_en = vld_last && !sched.fifo_out_full;

    assign state_dbg = state;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                // The frame_done cycle is still IDLE but must not restart a frame.
                if (start && !frame_done) begin
                    state_nxt = S_FILL;
                end
            end
            S_FILL: begin
                if (step && at_last) begin
                    state_nxt = S_DRAIN;
                end else if (step && at_first_emit) begin
                    state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                if (step && at_last) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (adv && (vld_nxt == '0)) begin
                    state_nxt = S_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            px <= '0;
            py <= '0;
        end else if (state == S_IDLE) begin
            px <= '0;
            py <= '0;
        end else if (step) begin
            if (px == X_LAST) begin
                px <= '0;
                py <= (py == Y_LAST) ? '0 : py + CW'(1);
            end else begin
                px <= px + CW'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld        <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            vld        <= vld_nxt;
            busy       <= (state_nxt != S_IDLE);
            frame_done <= done_nxt;
        end
    end

`ifdef WINDOW_SCHEDULER_STATS_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            frame_count <= '0;
            stall_count <= '0;
        end else begin
            if (frame_done) begin
                frame_count <= frame_count + 16'd1;
            end
            if (active && !step && (stall_count != 32'hFFFF_FFFF)) begin
                stall_count <= stall_count + 32'd1;
            end
        end
    end
`endif

    a_pop_not_empty: assert property (@(posedge clock) disable iff (!reset)
        sched.fifo_in_rd_en |-> !sched.fifo_in_empty);
    a_write_not_full: assert property (@(posedge clock) disable iff (!reset)
        sched.fifo_out_wr_en |-> !sched.fifo_out_full);

endmodule
